// File: rtl/sequence_frame_capture.sv
// Captures the WIDTH serial bits that follow a detector pulse and presents them
// as one parallel word on a valid/ready port, with a saturating frame counter.
module sequence_frame_capture #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data_in,
   input  logic             detected,
   input  logic             out_ready,
   output logic [WIDTH-1:0] frame_data,
   output logic             frame_valid,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] frame_count,
   output logic             o_dbg_state
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   // Output handshake: a transfer happens on any edge where frame_valid and
   // out_ready are both 1; frame_data is held while valid is up and ready is low.

   state_t            r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [CW-1:0]     r_bit_cnt;
   logic [WIDTH-1:0]  r_frame_data;
   logic              r_frame_valid;
   logic              r_overflow;
   logic [CNT_W-1:0]  r_frame_count;

   state_t            w_state_nxt;
   logic [WIDTH-1:0]  w_shift_nxt;
   logic [CW-1:0]     w_bit_cnt_nxt;
   logic              w_complete;
   logic              w_xfer;
   logic              w_load;
   logic              w_drop;
   logic [WIDTH-1:0]  w_frame_data_nxt;
   logic              w_frame_valid_nxt;
   logic [CNT_W-1:0]  w_frame_count_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_frame_data  <= '0;
         r_frame_valid <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_shift       <= w_shift_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_frame_data  <= w_frame_data_nxt;
         r_frame_valid <= w_frame_valid_nxt;
         r_overflow    <= w_drop;
         r_frame_count <= w_frame_count_nxt;
      end
   end

   // detected is deliberately ignored while capturing: no restart, no nesting.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_complete    = 1'b0;
      case (r_state)
         IDLE: begin
            if (detected) begin
               w_state_nxt   = CAPTURE;
               w_bit_cnt_nxt = '0;
            end
         end
         CAPTURE: begin
            w_shift_nxt   = {r_shift[WIDTH-2:0], data_in};
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
            if (r_bit_cnt == CW'(WIDTH - 1)) begin
               w_complete    = 1'b1;
               w_state_nxt   = IDLE;
               w_bit_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
         end
      endcase
   end

   // A completed word is loaded only if the output slot is free or being
   // emptied on this same edge; otherwise it is dropped and flagged.
   always_comb begin
      w_xfer            = r_frame_valid & out_ready;
      w_load            = w_complete & (~r_frame_valid | out_ready);
      w_drop            = w_complete & r_frame_valid & ~out_ready;
      w_frame_data_nxt  = r_frame_data;
      w_frame_valid_nxt = r_frame_valid;
      w_frame_count_nxt = r_frame_count;
      if (w_load) begin
         w_frame_data_nxt  = w_shift_nxt;
         w_frame_valid_nxt = 1'b1;
         if (r_frame_count != {CNT_W{1'b1}})
            w_frame_count_nxt = r_frame_count + CNT_W'(1);
      end else if (w_xfer) begin
         w_frame_valid_nxt = 1'b0;
      end
   end

   assign frame_data  = r_frame_data;
   assign frame_valid = r_frame_valid;
   assign busy        = (r_state == CAPTURE);
   assign overflow    = r_overflow;
   assign frame_count = r_frame_count;
   assign o_dbg_state = r_state;

endmodule

// File: doc/sequence_frame_capture.md
Name: sequence_frame_capture

Overview:
- Downstream consumer of the serial sequence detector.
- Watches the detector's one-cycle detected pulse and the same serial data_in stream, then captures the next WIDTH bits as a payload word.
- Presents the word on a valid/ready output port with a delivered-frame counter and an overflow indication.
- Sits between the detector and any parallel consumer (register file, FIFO, UART TX).

Parameters:
WIDTH  8  payload bits captured per detection; legal range >= 2
CNT_W  8  width of the delivered-frame counter

Ports:
clk          input   1        single system clock, rising-edge
reset        input   1        asynchronous, active-low reset (0 = reset asserted)
data_in      input   1        serial bit stream, the same stream that feeds the detector
detected     input   1        one-cycle pulse from the sequence detector; pattern just completed
out_ready    input   1        consumer can accept frame_data this cycle
frame_data   output  WIDTH    captured payload, first captured bit in MSB
frame_valid  output  1        frame_data holds an unconsumed frame
busy         output  1        capture in progress
overflow     output  1        one-cycle pulse: completed frame dropped
frame_count  output  CNT_W    number of frames loaded into the output register, saturating

Behaviour:
- Reset: asserting reset (low) immediately clears all state, with no dependence on clk.
  - frame_data = 0, frame_valid = 0, busy = 0, overflow = 0, frame_count = 0.
  - State = IDLE, shift register and bit counter = 0.
  - A partial capture is discarded.
- IDLE:
  - busy = 0.
  - On an edge with detected = 1: go to CAPTURE and clear the bit counter. data_in on that edge is NOT captured.
- CAPTURE:
  - busy = 1.
  - Each edge shifts data_in into the LSB of the shift register (MSB-first capture) and increments the bit counter.
  - detected is ignored; no restart and no nesting.
  - On the edge that shifts in bit WIDTH: return to IDLE and attempt the output load on that same edge.
- Latency: with detected sampled at edge N, payload bits are sampled at edges N+1 .. N+WIDTH. frame_valid is visible after edge N+WIDTH.
- Back-to-back frames: detected on the edge after completion (IDLE) starts a new capture, so there are no dead cycles beyond that edge.
- Output load, on the completion edge:
  - If frame_valid = 0, or frame_valid = 1 and out_ready = 1 (old frame consumed this edge):
    - frame_data <= completed word, frame_valid <= 1.
    - frame_count increments and saturates at 2^CNT_W-1.
  - If frame_valid = 1 and out_ready = 0:
    - The new word is dropped and overflow = 1 for exactly one cycle.
    - frame_data, frame_valid and frame_count are unchanged.
- Handshake:
  - A transfer occurs on an edge where frame_valid = 1 and out_ready = 1.
  - frame_valid clears after a transfer unless a new load occurs on the same edge, in which case it stays 1 with the new data.
  - frame_data is stable while frame_valid = 1 and out_ready = 0.
  - out_ready while frame_valid = 0 has no effect.
- overflow is 0 on every edge other than a drop edge.
- frame_count wraps never; it holds at its maximum value.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic capture:
  - Stimulus: reset low 2 cycles, release; detected pulse at edge 10; data_in = 1,0,1,0,0,1,0,1 at edges 11..18; out_ready = 1.
  - Response: busy = 1 after edges 10..17; frame_valid = 1 and frame_data = 0xA5 after edge 18; frame_valid = 0 after edge 19; frame_count = 1.
- Backpressure and overflow:
  - Stimulus: out_ready = 0; capture 0x3C, then a second detection capturing 0xFF.
  - Response: frame_data holds 0x3C throughout; overflow = 1 for one cycle at the second completion edge; frame_count = 1.
  - Then out_ready = 1: one transfer of 0x3C, then frame_valid = 0.
- Consume and load on the same edge:
  - Stimulus: 0x11 pending; out_ready = 1 exactly on the completion edge of frame 0x22.
  - Response: frame_valid stays 1, frame_data = 0x22, overflow = 0, frame_count = 2.
- Detected during capture:
  - Stimulus: extra detected pulses at edges N+3 and N+WIDTH.
  - Response: a single frame is delivered, equal to the bits at N+1..N+WIDTH; busy drops after edge N+WIDTH; no second capture starts.
- Reset mid-capture:
  - Stimulus: assert reset asynchronously (between edges) after 4 bits are captured.
  - Response: all outputs are 0 immediately, before the next clk edge; after release with no detected, no frame ever appears.
- Counter saturation:
  - Stimulus: with CNT_W = 2, deliver 5 frames with out_ready = 1.
  - Response: frame_count sequence 1, 2, 3, 3, 3.
